// File: rtl/s2axi_hp_wr_pkg.sv
// Shared constants and types for the HP0 write engine.
//   AXI3 field encodings used on the AW/W/B channels, burst geometry
//   (16 beats x 4 bytes) and the write FSM state type.
package r7ocm_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

  localparam int unsigned BURST_BEATS   = 16;
  localparam int unsigned BURST_BYTES   = 64;
  localparam logic [3:0]  AXI_LEN_BURST = 4'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wr_state_e;

endpackage

// File: rtl/s2axi_hp_wr_if.sv
// AXI3 write-channel bundle (AW, W, B) between the write engine and the
// PS AXI_HP0 slave port.
//   master : the write engine (drives aw*/w*/bready)
//   slave  : the HP0 port or a bench model (drives awready/wready/b*)
interface s2axi_hp_wr_if;

  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [5:0]  awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [5:0]  wid;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic [5:0]  bid;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awid, awvalid,
    output wdata, wstrb, wlast, wid, wvalid,
    output bready,
    input  awready, wready, bresp, bid, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awid, awvalid,
    input  wdata, wstrb, wlast, wid, wvalid,
    input  bready,
    output awready, wready, bresp, bid, bvalid
  );

endinterface

// File: rtl/s2axi_hp_wr_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO (pointers and count to zero)
//   push_i/data_i : write a word (never issued while full)
//   pop_i         : drop the head word (never issued while empty)
//   data_o        : current head word, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy
module r7ocm_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/s2axi_hp_wr.sv
// Write engine for the PS AXI_HP0 port: buffers 32-bit stream words and
// writes them to a DDR ring as fixed 16-beat AXI3 INCR bursts.
//   AXI_clk, rst_n : HP0 clock, asynchronous active-low reset
//   enable         : run control; low while idle flushes and zeroes state
//   s_data/s_valid/s_ready : sample stream input
//   wr_ptr         : ring offset just past the last acknowledged burst
//   overflow       : sticky, a word was offered while refused (enabled)
//   bus_err        : sticky, a burst response was not OKAY
//   AXI_HP0        : AW/W/B channels (master side)
module s2axi_hp_wr
  import r7ocm_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1E00_0000,
  parameter logic [31:0] RING_BYTES = 32'h0010_0000,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [5:0]  AXI_ID     = 6'd0
) (
  input  logic                 AXI_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [31:0]          wr_ptr,
  output logic                 overflow,
  output logic                 bus_err,
  s2axi_hp_wr_if.master        AXI_HP0
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_e   state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] wr_ptr_q, wr_ptr_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        overflow_q, overflow_d;
  logic        bus_err_q, bus_err_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          unused_w;

  assign s_ready    = enable && !fifo_full;
  assign fifo_push  = s_valid && s_ready;
  assign fifo_pop   = (state_q == DATA) && AXI_HP0.wready;
  assign fifo_flush = !enable && (state_q == IDLE);

  r7ocm_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (AXI_clk),
    .rst_ni  (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (s_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    offset_d   = offset_q;
    wr_ptr_d   = wr_ptr_q;
    awaddr_d   = awaddr_q;
    overflow_d = overflow_q;
    bus_err_d  = bus_err_q;

    if (enable && s_valid && !s_ready) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (enable && (fifo_count >= CW'(BURST_BEATS))) begin
          state_d  = ADDR;
          awaddr_d = BASE_ADDR + offset_q;
          beat_d   = '0;
        end else if (!enable) begin
          offset_d   = '0;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
          bus_err_d  = 1'b0;
        end
      end
      ADDR: begin
        if (AXI_HP0.awready) state_d = DATA;
      end
      DATA: begin
        if (AXI_HP0.wready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == AXI_LEN_BURST) state_d = RESP;
        end
      end
      RESP: begin
        if (AXI_HP0.bvalid) begin
          // Ring size is a power of two, so the mask performs the wrap.
          offset_d  = (offset_q + 32'(BURST_BYTES)) & (RING_BYTES - 32'd1);
          wr_ptr_d  = (offset_q + 32'(BURST_BYTES)) & (RING_BYTES - 32'd1);
          bus_err_d = bus_err_q | (AXI_HP0.bresp != AXI_RESP_OKAY);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      offset_q   <= '0;
      wr_ptr_q   <= '0;
      awaddr_q   <= '0;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      offset_q   <= offset_d;
      wr_ptr_q   <= wr_ptr_d;
      awaddr_q   <= awaddr_d;
      overflow_q <= overflow_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign wr_ptr   = wr_ptr_q;
  assign overflow = overflow_q;
  assign bus_err  = bus_err_q;

  assign AXI_HP0.awaddr  = awaddr_q;
  assign AXI_HP0.awlen   = AXI_LEN_BURST;
  assign AXI_HP0.awsize  = AXI_SIZE_4B;
  assign AXI_HP0.awburst = AXI_BURST_INCR;
  assign AXI_HP0.awlock  = '0;
  assign AXI_HP0.awcache = AXI_CACHE_BUF;
  assign AXI_HP0.awprot  = '0;
  assign AXI_HP0.awqos   = '0;
  assign AXI_HP0.awid    = AXI_ID;
  assign AXI_HP0.awvalid = (state_q == ADDR);

  // wdata is forced to zero outside DATA so reset leaves no stale RAM word visible.
  assign AXI_HP0.wdata   = (state_q == DATA) ? fifo_head : '0;
  assign AXI_HP0.wstrb   = 4'hF;
  assign AXI_HP0.wlast   = (state_q == DATA) && (beat_q == AXI_LEN_BURST);
  assign AXI_HP0.wid     = AXI_ID;
  assign AXI_HP0.wvalid  = (state_q == DATA);

  assign AXI_HP0.bready  = (state_q == RESP);

  assign unused_w = ^{AXI_HP0.bid, fifo_empty};

endmodule
